// File: rtl/gf2m_ds_mult_param.sv
// Digit-serial GF(2^M) multiplier with optional accumulate into the result register.
// The multiplier is consumed MSB digit first; each digit runs a DIGIT-step Horner chain.
module gf2m_ds_mult_param #(
   parameter int DATA_WIDTH = 163,
   parameter int DIGIT      = 8
) (
   input  logic                                                  clk,
   input  logic                                                  rst_n,
   input  logic                                                  start,
   input  logic                                                  mode,
   input  logic [DATA_WIDTH-1:0]                                 a,
   input  logic [DATA_WIDTH-1:0]                                 g,
   input  logic [((DATA_WIDTH + DIGIT - 1) / DIGIT) * DIGIT-1:0] b,
   output logic [DATA_WIDTH-1:0]                                 t_i_j,
   output logic                                                  busy,
   output logic                                                  done
);

   localparam int ITN = (DATA_WIDTH + DIGIT - 1) / DIGIT;
   localparam int BW  = ITN * DIGIT;
   localparam int CW  = (ITN > 1) ? $clog2(ITN) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_reg, state_next;
   logic [CW-1:0]         cnt_reg, cnt_next;
   logic [DATA_WIDTH-1:0] acc_reg, acc_next;
   logic [DATA_WIDTH-1:0] t_reg, t_next;
   logic [DATA_WIDTH-1:0] a_reg, g_reg;
   logic [BW-1:0]         b_reg;
   logic                  mode_reg;
   logic                  accept;
   logic [DIGIT-1:0]      digit;
   logic [DATA_WIDTH-1:0] horner [DIGIT+1];

   // b_reg shifts left once per RUN cycle, so the current digit is always at the top
   assign digit     = b_reg[BW-1 -: DIGIT];
   assign horner[0] = acc_reg;

   for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
      logic [DATA_WIDTH-1:0] xt;
      if (DATA_WIDTH == 1) begin : g_w1
         assign xt = horner[gi][0] ? g_reg : '0;
      end else begin : g_wn
         assign xt = {horner[gi][DATA_WIDTH-2:0], 1'b0} ^ (horner[gi][DATA_WIDTH-1] ? g_reg : '0);
      end
      assign horner[gi+1] = xt ^ (digit[DIGIT-1-gi] ? a_reg : '0);
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      acc_next   = acc_reg;
      t_next     = t_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
               cnt_next   = CW'(ITN - 1);
               acc_next   = '0;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            acc_next = horner[DIGIT];
            if (cnt_reg == '0) begin
               t_next     = mode_reg ? (horner[DIGIT] ^ t_reg) : horner[DIGIT];
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         acc_reg   <= '0;
         t_reg     <= '0;
         a_reg     <= '0;
         g_reg     <= '0;
         b_reg     <= '0;
         mode_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         acc_reg   <= acc_next;
         t_reg     <= t_next;
         if (accept) begin
            a_reg    <= a;
            g_reg    <= g;
            b_reg    <= b;
            mode_reg <= mode;
         end else if (state_reg == RUN) begin
            b_reg <= b_reg << DIGIT;
         end
      end
   end

   assign t_i_j = t_reg;
   assign busy  = (state_reg == RUN);
   assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_gf2m_ds_mult_param.sv
// Bench for gf2m_ds_mult_param at (163,8) and (4,3): directed table, corner sequences
// and random operations checked against a carry-less multiply + long-division model.
module tb_gf2m_ds_mult_param;

   localparam int MB = 163, DB = 8, ITB = 21, BWB = 168;
   localparam int MS = 4,   DS = 3, ITS = 2,  BWS = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic           start_b, mode_b, busy_b, done_b;
   logic [MB-1:0]  a_b, g_b, t_b;
   logic [BWB-1:0] b_b;
   logic           start_s, mode_s, busy_s, done_s;
   logic [MS-1:0]  a_s, g_s, t_s;
   logic [BWS-1:0] b_s;

   gf2m_ds_mult_param #(.DATA_WIDTH(MB), .DIGIT(DB)) dut_big (
      .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
      .a(a_b), .g(g_b), .b(b_b), .t_i_j(t_b), .busy(busy_b), .done(done_b));

   gf2m_ds_mult_param #(.DATA_WIDTH(MS), .DIGIT(DS)) dut_small (
      .clk(clk), .rst_n(rst_n), .start(start_s), .mode(mode_s),
      .a(a_s), .g(g_s), .b(b_s), .t_i_j(t_s), .busy(busy_s), .done(done_s));

   int n_cmp = 0;
   int n_err = 0;
   logic [255:0] model_t [2];

   typedef struct {
      int           sel;
      logic [255:0] av, bv, gv, exp;
      string        name;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] mask(input logic [255:0] v, input int w);
      logic [255:0] m;
      m = '0;
      for (int i = 0; i < w; i++) m[i] = 1'b1;
      return v & m;
   endfunction

   // Polynomial product over GF(2), then reduction by f = x^m + g from the top down
   function automatic logic [255:0] gf_mul(input int m, input logic [255:0] av,
                                           input logic [255:0] bv, input logic [255:0] gv);
      logic [511:0] p, f;
      p = '0;
      for (int i = 0; i < 256; i++)
         if (bv[i]) p = p ^ ({256'b0, av} << i);
      f = {256'b0, gv};
      f[m] = 1'b1;
      for (int k = 511; k >= m; k--)
         if (p[k]) p = p ^ (f << (k - m));
      return p[255:0];
   endfunction

   function automatic vec_t mk(input int sel, input logic [255:0] av, input logic [255:0] bv,
                               input logic [255:0] gv, input logic [255:0] exp, input string name);
      vec_t v;
      v.sel = sel; v.av = av; v.bv = bv; v.gv = gv; v.exp = exp; v.name = name;
      return v;
   endfunction

   task automatic drive(input int sel, input logic st, input logic md, input logic [255:0] av,
                        input logic [255:0] bv, input logic [255:0] gv);
      if (sel == 0) begin
         start_b = st; mode_b = md; a_b = av[MB-1:0]; b_b = bv[BWB-1:0]; g_b = gv[MB-1:0];
      end else begin
         start_s = st; mode_s = md; a_s = av[MS-1:0]; b_s = bv[BWS-1:0]; g_s = gv[MS-1:0];
      end
   endtask

   function automatic logic get_done(input int sel);
      return (sel == 0) ? done_b : done_s;
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? busy_b : busy_s;
   endfunction

   function automatic logic [255:0] get_t(input int sel);
      return (sel == 0) ? 256'(t_b) : 256'(t_s);
   endfunction

   task automatic drive_garbage(input int sel);
      drive(sel, 1'b0, 1'($urandom), rand256(), rand256(), rand256());
   endtask

   // Entered at the falling edge just after the accepting edge; n counts edges since then
   task automatic wait_done(input int sel, input logic [255:0] t0, output int n,
                            output int busycnt, output bit t_moved);
      n = 0; busycnt = 0; t_moved = 1'b0;
      while (!get_done(sel) && n < 200) begin
         if (get_busy(sel)) busycnt++;
         if (get_t(sel) !== t0) t_moved = 1'b1;
         @(posedge clk); n++; @(negedge clk);
      end
   endtask

   task automatic run_op(input int sel, input logic md, input logic [255:0] av, input logic [255:0] bv,
                         input logic [255:0] gv, input logic [255:0] exp, input string name);
      logic [255:0] t0;
      int n, bc, itn;
      bit mv;
      itn = (sel == 0) ? ITB : ITS;
      @(negedge clk);
      drive(sel, 1'b1, md, av, bv, gv);
      t0 = get_t(sel);
      @(posedge clk); @(negedge clk);
      drive_garbage(sel);
      wait_done(sel, t0, n, bc, mv);
      check({name, " latency"}, 256'(n), 256'(itn));
      check({name, " busy_cycles"}, 256'(bc), 256'(itn));
      check({name, " t_held_in_run"}, 256'(mv), 256'(0));
      check({name, " result"}, get_t(sel), exp);
      $display("op %s sel=%0d mode=%0d lat=%0d t=%h", name, sel, md, n, get_t(sel));
      @(posedge clk); @(negedge clk);
      check({name, " done_one_cycle"}, 256'(get_done(sel)), 256'(0));
      model_t[sel] = exp;
   endtask

   initial begin
      logic [255:0] av, bv, gv, e, t0;
      logic md;
      int n, bc, dc;
      bit mv;

      tbl[0]  = mk(0, 256'h1, 256'h1, 256'hC9, 256'h1, "one_times_one");
      tbl[1]  = mk(0, 256'b1 << 162, 256'h2, 256'hC9, 256'hC9, "x163_reduced");
      tbl[2]  = mk(0, 256'h3, 256'h5, 256'hC9, 256'hF, "small_product");
      tbl[3]  = mk(0, 256'h1, 256'b1 << 5, 256'hC9, 256'h20, "b_bit5");
      tbl[4]  = mk(0, 256'b1 << 100, 256'b1 << 62, 256'hC9, 256'b1 << 162, "top_bit_no_reduce");
      tbl[5]  = mk(0, 256'h0, 256'hFF, 256'hC9, 256'h0, "zero_a");
      tbl[6]  = mk(1, 256'h2, 256'h08, 256'h3, 256'h3, "s_x_times_x3");
      tbl[7]  = mk(1, 256'h3, 256'h3, 256'h3, 256'h5, "s_square");
      tbl[8]  = mk(1, 256'h8, 256'h8, 256'h3, 256'hC, "s_x6");
      tbl[9]  = mk(1, 256'h1, 256'h20, 256'h3, 256'h6, "s_b_above_m");
      tbl[10] = mk(1, 256'hF, 256'h1, 256'h3, 256'hF, "s_times_one");

      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      model_t[0] = '0; model_t[1] = '0;
      #12;
      check("reset t_big", get_t(0), '0);
      check("reset busy_big", 256'(busy_b), '0);
      check("reset done_big", 256'(done_b), '0);
      check("reset t_small", get_t(1), '0);
      check("reset busy_small", 256'(busy_s), '0);
      check("reset done_small", 256'(done_s), '0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i])
         run_op(tbl[i].sel, 1'b0, tbl[i].av, tbl[i].bv, tbl[i].gv, tbl[i].exp, tbl[i].name);

      // accumulate right after reset, then a back-to-back accumulate accepted in DONE
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      model_t[0] = '0; model_t[1] = '0;
      drive(0, 1'b1, 1'b1, 256'h1, 256'h1, 256'hC9);
      @(posedge clk); @(negedge clk);
      drive_garbage(0);
      wait_done(0, '0, n, bc, mv);
      check("b2b first latency", 256'(n), 256'(ITB));
      check("b2b first result", get_t(0), 256'h1);
      drive(0, 1'b1, 1'b1, 256'h1, 256'h1, 256'hC9);
      t0 = get_t(0);
      @(posedge clk); @(negedge clk);
      drive_garbage(0);
      check("b2b no bubble busy", 256'(busy_b), 256'h1);
      check("b2b no bubble done", 256'(done_b), 256'h0);
      wait_done(0, t0, n, bc, mv);
      check("b2b second latency", 256'(n), 256'(ITB));
      check("b2b second result", get_t(0), 256'h0);
      $display("op b2b_accumulate sel=0 mode=1 lat=%0d t=%h", n, get_t(0));
      model_t[0] = '0;
      @(posedge clk); @(negedge clk);

      // start pulses during RUN must be ignored
      drive(0, 1'b1, 1'b0, 256'h3, 256'h5, 256'hC9);
      @(posedge clk); @(negedge clk);
      n = 0;
      while (!done_b && n < 200) begin
         if (n >= 2 && n <= 9) drive(0, 1'b1, 1'b1, 256'h7, 256'h9, 256'h1B);
         else drive(0, 1'b0, 1'b0, 256'h7, 256'h9, 256'h1B);
         @(posedge clk); n++; @(negedge clk);
      end
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      check("ignored_start latency", 256'(n), 256'(ITB));
      check("ignored_start result", get_t(0), 256'hF);
      $display("op ignored_start sel=0 mode=0 lat=%0d t=%h", n, get_t(0));
      model_t[0] = 256'hF;
      @(posedge clk); @(negedge clk);

      // reset in the middle of RUN aborts the operation
      drive(0, 1'b1, 1'b0, 256'h1, 256'h1, 256'hC9);
      @(posedge clk); @(negedge clk);
      drive_garbage(0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun_reset t", get_t(0), '0);
      check("midrun_reset busy", 256'(busy_b), '0);
      check("midrun_reset done", 256'(done_b), '0);
      check("midrun_reset t_small", get_t(1), '0);
      model_t[0] = '0; model_t[1] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      dc = 0;
      repeat (30) begin
         @(negedge clk);
         if (done_b) dc++;
      end
      check("midrun_reset no_done", 256'(dc), '0);
      $display("op midrun_reset sel=0 done_pulses=%0d t=%h", dc, get_t(0));
      run_op(0, 1'b0, 256'h3, 256'h5, 256'hC9, 256'hF, "after_reset");

      for (int k = 0; k < 2000; k++) begin
         int sel, m, bw;
         sel = (k < 1000) ? 0 : 1;
         m   = (sel == 0) ? MB : MS;
         bw  = (sel == 0) ? BWB : BWS;
         av  = mask(rand256(), m);
         bv  = mask(rand256(), bw);
         gv  = mask(rand256(), m);
         md  = 1'($urandom);
         e   = gf_mul(m, av, bv, gv);
         if (md) e = e ^ model_t[sel];
         run_op(sel, md, av, bv, gv, e, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gf2m_ds_mult_param.md
GF2M_DS_MULT_PARAM -- requirements
Module: gf2m_ds_mult_param

Interface
REQ-001 Parameter DATA_WIDTH, default 163: field degree M; reduction polynomial f(x)=x^M+g(x).
REQ-002 Parameter DIGIT, default 8: digit size D, 1<=D<=DATA_WIDTH.
REQ-003 Localparam ITN = ceil(DATA_WIDTH/DIGIT): digit count; 21 at defaults.
REQ-004 One clock; reset is asynchronous and active-low (clk, rst_n).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request; sampled high at rising edge when accepted.
REQ-008 mode  input  1  0 = multiply, 1 = multiply-accumulate; latched on accept.
REQ-009 a  input  DATA_WIDTH  multiplicand polynomial; latched on accept.
REQ-010 g  input  DATA_WIDTH  low terms of f(x), bit i = coefficient of x^i; latched on accept.
REQ-011 b  input  ITN*DIGIT  multiplier polynomial, zero-padded above bit DATA_WIDTH-1; latched on accept.
REQ-012 t_i_j  output  DATA_WIDTH  result register.
REQ-013 busy  output  1  high while digits are being processed.
REQ-014 done  output  1  one-cycle pulse when t_i_j becomes valid.

Function
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 start accepted only in IDLE or DONE; start in RUN ignored, no operand latch, no state change.
REQ-017 On accept: latch a, g, b, mode; digit counter = ITN-1; working accumulator T = 0; go RUN; busy=1 from next cycle.
REQ-018 Digits consumed MSB-first: digit i = b[DIGIT*i +: DIGIT], i = ITN-1 down to 0, one digit per clock.
REQ-019 Per digit, combinational Horner over bits j=DIGIT-1..0: T = xtime(T) XOR (b_bit_j ? a : 0).
REQ-020 xtime(T): shift left 1; if shifted-out bit (old T[M-1]) is 1, XOR latched g into result; all values stay DATA_WIDTH bits.
REQ-021 After digit 0 (ITN-th RUN cycle): t_i_j = T (mode 0) or T XOR previous t_i_j (mode 1); go DONE; busy=0.
REQ-022 Latency: start sampled at edge k -> t_i_j valid and done=1 after edge k+ITN; done high exactly one cycle.
REQ-023 DONE returns to IDLE next cycle unless start accepted in that cycle (back-to-back accept, no bubble).
REQ-024 t_i_j holds its value in IDLE, RUN and DONE until next result write; intermediate T never visible on t_i_j.
REQ-025 Result equals a*b mod f(x) over GF(2) for any a, b, including b bits above M-1.
REQ-026 Changes on a, b, g, mode after accept do not affect the running operation.

Reset
REQ-027 rst_n low, asynchronously: state IDLE, t_i_j=0, busy=0, done=0, T=0, counter=0, latched operands=0.
REQ-028 Reset mid-RUN aborts the operation; no done pulse; after release the block accepts start normally.
REQ-029 Accumulate mode immediately after reset accumulates onto t_i_j=0.

Verification
REQ-030 Defaults, g=0xC9, mode=0, a=1, b=1, start one cycle -> busy 21 cycles, done pulse after edge k+21, t_i_j=1.
REQ-031 Defaults, g=0xC9, a=x^162 (bit 162 only), b=0x2 -> t_i_j=0xC9 (x^163 reduced).
REQ-032 Defaults, mode=1, two back-to-back ops a=1,b=1 (start in DONE cycle) -> t_i_j=1 then 0; second done exactly 21 cycles after second accept.
REQ-033 Start re-asserted with different a in cycles 3..10 of RUN -> ignored; result and done timing of first op unchanged.
REQ-034 rst_n pulsed low at RUN cycle 10 -> t_i_j=0, busy=0, done never pulses; new op after release gives correct result.
REQ-035 DATA_WIDTH=4, DIGIT=3 (ITN=2, b 6 bits), g=0x3, a=0x2, b=0x08 -> t_i_j=0x3; random a,b vs software GF(2^m) model at both configs, 1000 ops each.
